// File: rtl/sram_arbiter_if.sv
// Channel-side and SRAM-side signals of the SRAM arbiter.
// slave is the arbiter's view; master is the requesters plus the SRAM model.
interface sram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int N_CH   = 2
);
    logic [N_CH-1:0]        ch_req;
    logic [N_CH-1:0]        ch_we;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH*DATA_W-1:0] ch_rdata;
    logic [N_CH-1:0]        ch_ack;
    logic [ADDR_W-1:0]      address;
    logic [DATA_W-1:0]      data_o;
    logic [DATA_W-1:0]      data_i;
    logic                   rden;
    logic                   wren;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, data_i,
        output ch_rdata, ch_ack, address, data_o, rden, wren
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, data_i,
        input  ch_rdata, ch_ack, address, data_o, rden, wren
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM among N_CH requesters: IDLE grants, ACCESS
// drives the strobes for WAIT_CYC+1 cycles, DONE pulses the channel's ack.
module sram_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 32,
    parameter int N_CH     = 2,
    parameter int WAIT_CYC = 0,
    parameter int RR_MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                         state;
    logic [3:0]                     cnt;
    logic [IDX_W-1:0]               gnt;
    logic [IDX_W-1:0]               last_grant;
    logic [ADDR_W-1:0]              address_q;
    logic [DATA_W-1:0]              data_o_q;
    logic                           rden_q;
    logic                           wren_q;
    logic [N_CH-1:0]                ack_q;
    logic [N_CH-1:0][DATA_W-1:0]    rdata_q;

    logic [N_CH-1:0][ADDR_W-1:0]    addr_a;
    logic [N_CH-1:0][DATA_W-1:0]    wdata_a;
    logic                           found;
    logic [IDX_W-1:0]               gnt_nxt;
    logic [IDX_W-1:0]               cand;

    assign addr_a  = bus.ch_addr;
    assign wdata_a = bus.ch_wdata;

    // Round-robin rotates the search origin to just past the last winner.
    always_comb begin
        found   = 1'b0;
        gnt_nxt = '0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (RR_MODE != 0)
                cand = IDX_W'((int'(last_grant) + 1 + i) % N_CH);
            else
                cand = IDX_W'(i);
            if (!found && bus.ch_req[cand]) begin
                found   = 1'b1;
                gnt_nxt = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= '0;
            last_grant <= IDX_W'(N_CH - 1);
            address_q  <= '0;
            data_o_q   <= '0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            ack_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= '0;
                    if (found) begin
                        gnt        <= gnt_nxt;
                        last_grant <= gnt_nxt;
                        address_q  <= addr_a[gnt_nxt];
                        data_o_q   <= wdata_a[gnt_nxt];
                        rden_q     <= !bus.ch_we[gnt_nxt];
                        wren_q     <= bus.ch_we[gnt_nxt];
                        cnt        <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'(WAIT_CYC)) begin
                        // wren_q still reflects the latched direction here
                        if (!wren_q) rdata_q[gnt] <= bus.data_i;
                        address_q <= '0;
                        data_o_q  <= '0;
                        rden_q    <= 1'b0;
                        wren_q    <= 1'b0;
                        ack_q     <= N_CH'(1) << gnt;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    ack_q <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.address  = address_q;
    assign bus.data_o   = data_o_q;
    assign bus.rden     = rden_q;
    assign bus.wren     = wren_q;
    assign bus.ch_ack   = ack_q;
    assign bus.ch_rdata = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: three arbiter configurations (fixed/W0, fixed/W3, RR/3ch)
// driven from one linear sequence with hand-computed expectations.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.DATA_W(16), .ADDR_W(32), .N_CH(2)) b0 ();
    sram_arbiter_if #(.DATA_W(16), .ADDR_W(32), .N_CH(2)) b1 ();
    sram_arbiter_if #(.DATA_W(16), .ADDR_W(32), .N_CH(3)) b2 ();

    sram_arbiter #(.DATA_W(16), .ADDR_W(32), .N_CH(2), .WAIT_CYC(0), .RR_MODE(0))
        u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
    sram_arbiter #(.DATA_W(16), .ADDR_W(32), .N_CH(2), .WAIT_CYC(3), .RR_MODE(0))
        u1 (.clk(clk), .rst(rst1), .bus(b1.slave));
    sram_arbiter #(.DATA_W(16), .ADDR_W(32), .N_CH(3), .WAIT_CYC(0), .RR_MODE(1))
        u2 (.clk(clk), .rst(rst2), .bus(b2.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are settled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        b0.ch_req = '0; b0.ch_we = '0; b0.ch_addr = '0; b0.ch_wdata = '0; b0.data_i = '0;
        b1.ch_req = '0; b1.ch_we = '0; b1.ch_addr = '0; b1.ch_wdata = '0; b1.data_i = '0;
        b2.ch_req = '0; b2.ch_we = '0; b2.ch_addr = '0; b2.ch_wdata = '0; b2.data_i = '0;
        tick(); tick();

        chk("rst_rden0",   b0.rden,     0);
        chk("rst_wren0",   b0.wren,     0);
        chk("rst_addr0",   b0.address,  0);
        chk("rst_ack0",    b0.ch_ack,   0);
        chk("rst_rdata0",  b0.ch_rdata, 0);
        chk("rst_ack2",    b2.ch_ack,   0);
        chk("rst_rdata2",  b2.ch_rdata, 0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        tick();
        chk("idle_rden0",  b0.rden,     0);

        // ch1 read of 0x100, single-cycle access
        b0.ch_addr = {32'h0000_0100, 32'h0};
        b0.data_i  = 16'hBEEF;
        b0.ch_req  = 2'b10;
        tick();
        chk("rd_rden",     b0.rden,     1);
        chk("rd_wren",     b0.wren,     0);
        chk("rd_addr",     b0.address,  32'h100);
        chk("rd_noack",    b0.ch_ack,   0);
        tick();
        chk("rd_ack",      b0.ch_ack,   2'b10);
        chk("rd_rdata1",   b0.ch_rdata[31:16], 16'hBEEF);
        chk("rd_done_rden", b0.rden,    0);
        chk("rd_done_addr", b0.address, 0);
        b0.ch_req = 2'b00;
        tick();
        chk("rd_ack_pulse", b0.ch_ack,  0);

        // simultaneous ch0/ch1 under fixed priority
        b0.ch_addr = {32'h0000_0020, 32'h0000_0010};
        b0.data_i  = 16'h1111;
        b0.ch_req  = 2'b11;
        tick();
        chk("fp_addr0",    b0.address,  32'h10);
        tick();
        chk("fp_ack0",     b0.ch_ack,   2'b01);
        chk("fp_rdata0",   b0.ch_rdata[15:0], 16'h1111);
        b0.ch_req = 2'b10;
        tick();
        chk("fp_gap_ack",  b0.ch_ack,   0);
        chk("fp_gap_rden", b0.rden,     0);
        tick();
        chk("fp_addr1",    b0.address,  32'h20);
        b0.data_i = 16'h2222;
        tick();
        chk("fp_ack1",     b0.ch_ack,   2'b10);
        chk("fp_rdata1",   b0.ch_rdata[31:16], 16'h2222);
        chk("fp_rdata0_hold", b0.ch_rdata[15:0], 16'h1111);
        b0.ch_req = 2'b00;
        tick();

        // ch0 write, request and inputs dropped during ACCESS
        b0.ch_we    = 2'b01;
        b0.ch_addr  = {32'h0, 32'h0000_0044};
        b0.ch_wdata = {16'h0, 16'hAAAA};
        b0.ch_req   = 2'b01;
        tick();
        chk("drop_wren",   b0.wren,     1);
        chk("drop_rden",   b0.rden,     0);
        chk("drop_data_o", b0.data_o,   16'hAAAA);
        chk("drop_addr",   b0.address,  32'h44);
        b0.ch_req   = 2'b00;
        b0.ch_addr  = {32'h0, 32'h0000_0055};
        b0.ch_wdata = {16'h0, 16'h5555};
        tick();
        chk("drop_ack",    b0.ch_ack,   2'b01);
        chk("drop_rdata0", b0.ch_rdata[15:0], 16'h1111);
        chk("drop_data_o0", b0.data_o,  0);
        tick();
        chk("drop_ack_once", b0.ch_ack, 0);
        tick();
        chk("drop_no_regrant", b0.wren, 0);

        // WAIT_CYC=3 write: four wren cycles then ack
        b1.ch_we    = 2'b01;
        b1.ch_addr  = {32'h0, 32'h0000_0020};
        b1.ch_wdata = {16'h0, 16'h1234};
        b1.data_i   = 16'hDEAD;
        b1.ch_req   = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("w3_wren%0d", i),   b1.wren,   1);
            chk($sformatf("w3_data_o%0d", i), b1.data_o, 16'h1234);
            chk($sformatf("w3_addr%0d", i),   b1.address, 32'h20);
            chk($sformatf("w3_noack%0d", i),  b1.ch_ack, 0);
        end
        tick();
        chk("w3_wren_off", b1.wren,     0);
        chk("w3_ack",      b1.ch_ack,   2'b01);
        chk("w3_rdata",    b1.ch_rdata, 0);
        b1.ch_req = 2'b00;
        tick();

        // reset in 2nd ACCESS cycle aborts the read
        b1.ch_we   = 2'b00;
        b1.ch_addr = {32'h0000_0030, 32'h0};
        b1.data_i  = 16'h5A5A;
        b1.ch_req  = 2'b10;
        tick();
        chk("ra_rden1",    b1.rden,     1);
        tick();
        chk("ra_rden2",    b1.rden,     1);
        rst1 = 1'b1;
        b1.ch_req = 2'b00;
        tick();
        chk("ra_rden",     b1.rden,     0);
        chk("ra_wren",     b1.wren,     0);
        chk("ra_addr",     b1.address,  0);
        chk("ra_data_o",   b1.data_o,   0);
        chk("ra_ack",      b1.ch_ack,   0);
        chk("ra_rdata",    b1.ch_rdata, 0);
        rst1 = 1'b0;
        b1.ch_req = 2'b10;
        tick();
        chk("ra_idle_grant", b1.rden,   1);
        chk("ra_idle_addr",  b1.address, 32'h30);
        tick(); tick(); tick();
        chk("ra_noack",    b1.ch_ack,   0);
        tick();
        chk("ra_ack",      b1.ch_ack,   2'b10);
        chk("ra_rdata1",   b1.ch_rdata[31:16], 16'h5A5A);
        b1.ch_req = 2'b00;
        tick();

        // round-robin with all three channels requesting continuously
        b2.ch_addr = {32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
        b2.ch_req  = 3'b111;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("rr_addr%0d", g), b2.address, 64'h1000 + 64'(g % 3));
            tick();
            chk($sformatf("rr_ack%0d", g),  b2.ch_ack,  64'(3'b001 << (g % 3)));
            tick();
        end
        b2.ch_req = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
- REQ-001: Parameter DATA_W, default 16: width of SRAM data and of each channel's data words.
- REQ-002: Parameter ADDR_W, default 32: width of SRAM address and of each channel's address.
- REQ-003: Parameter N_CH, default 2: number of requesting channels (2..8); channel 0 is the instruction port.
- REQ-004: Parameter WAIT_CYC, default 0: extra SRAM access cycles beyond one (0..15).
- REQ-005: Parameter RR_MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- REQ-006: Ports are listed below as name, direction, width, meaning.
  - clk, in, 1: single clock; all state on rising edge.
  - rst, in, 1: reset, synchronous and active-high.
  - ch_req, in, N_CH: per-channel access request, held until ack.
  - ch_we, in, N_CH: per-channel write enable (1 = write, 0 = read).
  - ch_addr, in, N_CH*ADDR_W: per-channel address, channel k in bits [k*ADDR_W +: ADDR_W].
  - ch_wdata, in, N_CH*DATA_W: per-channel write data.
  - ch_rdata, out, N_CH*DATA_W: per-channel read data, valid while that channel's ch_ack is high.
  - ch_ack, out, N_CH: one-cycle completion pulse per channel.
  - address, out, ADDR_W: SRAM address.
  - data_o, out, DATA_W: SRAM write data.
  - data_i, in, DATA_W: SRAM read data.
  - rden, out, 1: SRAM read strobe.
  - wren, out, 1: SRAM write strobe.

Function
- REQ-007: FSM states are IDLE, ACCESS and DONE; all outputs are registered.
- REQ-008: In IDLE with any ch_req high, the block shall grant one channel and latch its addr, we and wdata; next state is ACCESS. Otherwise it stays in IDLE.
- REQ-009: In fixed-priority mode, the lowest-index requesting channel wins.
- REQ-010: In round-robin mode, search starts at (last_grant+1) mod N_CH; last_grant resets to N_CH-1.
- REQ-011: ACCESS lasts exactly WAIT_CYC+1 cycles, counted by a 4-bit counter.
- REQ-012: Throughout ACCESS, address and data_o shall hold the latched values; rden = !we and wren = we.
- REQ-013: On the last ACCESS cycle, data_i shall be captured into the granted channel's ch_rdata for reads only; for writes, ch_rdata is unchanged. Next state is DONE.
- REQ-014: In DONE, the granted channel's ch_ack shall be 1 for one cycle and rden/wren shall be 0; next state is IDLE.
- REQ-015: Latency: req seen in IDLE at cycle t gives strobes in cycles t+1..t+1+WAIT_CYC and ch_ack in cycle t+2+WAIT_CYC.
- REQ-016: Minimum spacing between grants is WAIT_CYC+3 cycles.
- REQ-017: Outside ACCESS, address, data_o, rden and wren shall be 0.
- REQ-018: rden and wren shall never be high together.
- REQ-019: At most one ch_ack bit shall be high in any cycle.
- REQ-020: ch_rdata of non-granted channels shall hold its previous value.
- REQ-021: If ch_req drops or channel inputs change during ACCESS, the access shall complete with the latched values and ack shall still pulse.
- REQ-022: A channel that keeps ch_req high after its ack is treated as a new request in the following IDLE cycle.

Reset
- REQ-023: When rst is high at a clock edge, the FSM shall go to IDLE, the counter to 0, and last_grant to N_CH-1.
- REQ-024: Reset shall also clear address, data_o, rden, wren, ch_ack and all ch_rdata to 0.
- REQ-025: Reset asserted during ACCESS or DONE shall abort the transfer with no ack, and strobes shall be 0 in the next cycle.
- REQ-026: Reset has priority over all requests in the same cycle.

Verification
- REQ-027: N_CH=2, WAIT_CYC=0: ch1 reads addr 0x100 with data_i=0xBEEF. Required: rden for 1 cycle with address=0x100, then ch_ack=2'b10 and ch1 rdata=0xBEEF.
- REQ-028: Fixed priority: ch0 and ch1 request in the same cycle. Required: ch0 is acked first, then ch1 is acked WAIT_CYC+3 cycles later.
- REQ-029: RR_MODE=1, N_CH=3: all channels hold req for 6 grants. Required: grant order 0,1,2,0,1,2.
- REQ-030: WAIT_CYC=3: ch0 writes 0x1234 to 0x20. Required: wren high for exactly 4 cycles with data_o=0x1234, then ack; rdata unchanged.
- REQ-031: rst asserted in the 2nd ACCESS cycle with WAIT_CYC=3. Required: next cycle all outputs 0, no ack, and the FSM in IDLE.
- REQ-032: Requester drops ch_req in the 1st ACCESS cycle. Required: access completes and ack still pulses once.
